// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbitration scheduler.
package div_arb_pkg;

  localparam int W           = 8;
  localparam int TIMEOUT_CYC = 63;

  localparam logic [W-1:0] QUO_DIV0 = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_Q = 3'd2,
    ST_LOAD_M = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its index, searching upward from
// i_ptr and wrapping back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int          v_sum;
  logic [IW-1:0] v_idx;

  // First requester at or above the pointer wins, with wrap-around.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_sum = 0;
    v_idx = '0;
    for (int k = 0; k < N; k++) begin
      v_sum = int'(i_ptr) + k;
      if (v_sum >= N) v_sum = v_sum - N;
      v_idx = IW'(v_sum);
      if (!o_any && i_req[v_idx]) begin
        o_any        = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_idx        = v_idx;
      end
    end
  end

endmodule

// File: rtl/div_arb_sched.sv
// Shares one external non-restoring divider among NUM_REQ requesters.
// Round-robin pick in IDLE, three-beat operand load (00, dividend, divisor),
// wait for div_fin, single-cycle response. A zero divisor skips the divider
// and answers immediately with an error.
// Optional build macro DIV_ARB_TIMEOUT_EN: abandons WAIT after TIMEOUT_CYC
// cycles without div_fin and answers with an error and zero results.
module div_arb_sched #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_dividend,
  input  logic [NUM_REQ*W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [W-1:0]         rsp_quo,
  output logic [W-1:0]         rsp_rem,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 div_start,
  output logic [W-1:0]         div_in_bus,
  input  logic                 div_fin,
  input  logic [W-1:0]         div_quo,
  input  logic [W-1:0]         div_rem
);
  import div_arb_pkg::*;

  state_t                    r_state;
  logic [1:0]                r_ptr;
  logic [1:0]                r_id;
  logic [W-1:0]              r_a;
  logic [W-1:0]              r_b;
  logic                      r_rsp_valid;
  logic [1:0]                r_rsp_id;
  logic [W-1:0]              r_rsp_quo;
  logic [W-1:0]              r_rsp_rem;
  logic                      r_rsp_err;
  logic                      r_busy;
  logic                      r_div_start;
  logic [W-1:0]              r_div_in_bus;
`ifdef DIV_ARB_TIMEOUT_EN
  logic [5:0]                r_tmo;
`endif

  logic [NUM_REQ-1:0]        w_gnt;
  logic [1:0]                w_idx;
  logic                      w_any;
  logic [NUM_REQ-1:0][W-1:0] w_dvd_v;
  logic [NUM_REQ-1:0][W-1:0] w_dvs_v;
  logic [W-1:0]              w_dvd;
  logic [W-1:0]              w_dvs;

  rr_arbiter #(.N(NUM_REQ), .IW(2)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_dvd_v = req_dividend;
  assign w_dvs_v = req_divisor;
  assign w_dvd   = w_dvd_v[w_idx];
  assign w_dvs   = w_dvs_v[w_idx];

  // Ack is combinational so the operands are taken on the same edge the
  // requester sees its grant; gated by rst so it is 0 during reset.
  assign req_ack = (rst && r_state == ST_IDLE && w_any) ? w_gnt : '0;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_quo    = r_rsp_quo;
  assign rsp_rem    = r_rsp_rem;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;
  assign div_start  = r_div_start;
  assign div_in_bus = r_div_in_bus;

  // Scheduler FSM; every output is registered against the state it enters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_quo    <= '0;
      r_rsp_rem    <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_in_bus <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      r_rsp_valid  <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_in_bus <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id   <= w_idx;
            r_a    <= w_dvd;
            r_b    <= w_dvs;
            r_busy <= 1'b1;
            if (w_dvs == '0) begin
              // Divide-by-zero never reaches the divider.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_idx;
              r_rsp_err   <= 1'b1;
              r_rsp_quo   <= W'(QUO_DIV0);
              r_rsp_rem   <= w_dvd;
            end else begin
              r_state     <= ST_LOAD_A;
              r_div_start <= 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          r_state      <= ST_LOAD_Q;
          r_div_in_bus <= r_a;
        end
        ST_LOAD_Q: begin
          r_state      <= ST_LOAD_M;
          r_div_in_bus <= r_b;
        end
        ST_LOAD_M: begin
          r_state <= ST_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        ST_WAIT: begin
          if (div_fin) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quo   <= div_quo;
            r_rsp_rem   <= div_rem;
            r_rsp_err   <= 1'b0;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (r_tmo == 6'(TIMEOUT_CYC - 1)) begin
            // This was the last allowed WAIT cycle; give up on the divider.
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quo   <= '0;
            r_rsp_rem   <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 6'd1;
          end
`endif
        end
        ST_RESP: begin
          r_ptr   <= r_id + 2'd1;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
